// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl
// Description : Game-flow controller for the VGA Pong datapath. Sequences the
//               ball engine through idle/serve/play/pause/game-over, keeps the
//               BCD paddle-hit score and the remaining lives.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl #(
    parameter int LIVES        = 3,    // lives per game, 1..7
    parameter int MISS_Y       = 470,  // ball_y at or below this line is a miss
    parameter int PAUSE_FRAMES = 60    // frames the ball is held after a miss
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       serve_btn,
    input  logic       paddle_hit,
    input  logic [8:0] ball_y,
    output logic       ball_run,
    output logic       ball_recenter,
    output logic [7:0] score_bcd,
    output logic [2:0] lives_left,
    output logic       game_over,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_PAUSE = 3'd2,
        S_SERVE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [2:0] c_LIVES      = 3'(LIVES);
    localparam logic [8:0] c_MISS_Y     = 9'(MISS_Y);
    localparam logic [7:0] c_PAUSE_LAST = 8'(PAUSE_FRAMES - 1);

    state_t     r_state;
    logic [7:0] r_pause_cnt;
    logic       r_serve_sync1;
    logic       r_serve_sync2;
    logic       r_serve_prev;

    logic       w_serve_ev;
    logic       w_miss;
    logic [7:0] w_score_inc;
    state_t     w_state_nxt;
    logic [7:0] w_score_nxt;
    logic [2:0] w_lives_nxt;
    logic [7:0] w_pause_nxt;

    // Bring the asynchronous button into the clock domain and keep the last value for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_serve_sync1 <= 1'b0;
            r_serve_sync2 <= 1'b0;
            r_serve_prev  <= 1'b0;
        end else begin
            r_serve_sync1 <= serve_btn;
            r_serve_sync2 <= r_serve_sync1;
            r_serve_prev  <= r_serve_sync2;
        end
    end

    // Rising edge of the synchronised button: one event per press however long it is held
    assign w_serve_ev = r_serve_sync2 & ~r_serve_prev;
    assign w_miss     = frame_tick & (ball_y >= c_MISS_Y);
    assign state_o    = r_state;

    // Saturating two-digit BCD increment of the score
    always_comb begin
        w_score_inc = score_bcd;
        if (score_bcd == 8'h99) begin
            w_score_inc = 8'h99;
        end else if (score_bcd[3:0] == 4'd9) begin
            w_score_inc = {score_bcd[7:4] + 4'd1, 4'd0};
        end else begin
            w_score_inc = {score_bcd[7:4], score_bcd[3:0] + 4'd1};
        end
    end

    // Next-state and counter logic; a hit in the same cycle as a miss is scored first
    always_comb begin
        w_state_nxt = r_state;
        w_score_nxt = score_bcd;
        w_lives_nxt = lives_left;
        w_pause_nxt = r_pause_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_serve_ev) begin
                    w_state_nxt = S_PLAY;
                    w_score_nxt = 8'h00;
                    w_lives_nxt = c_LIVES;
                end
            end
            S_PLAY: begin
                if (paddle_hit) begin
                    w_score_nxt = w_score_inc;
                end
                if (w_miss) begin
                    if (lives_left <= 3'd1) begin
                        w_state_nxt = S_OVER;
                        w_lives_nxt = 3'd0;
                    end else begin
                        w_state_nxt = S_PAUSE;
                        w_lives_nxt = lives_left - 3'd1;
                        w_pause_nxt = 8'd0;
                    end
                end
            end
            S_PAUSE: begin
                if (frame_tick) begin
                    if (r_pause_cnt == c_PAUSE_LAST) begin
                        w_state_nxt = S_SERVE;
                    end else begin
                        w_pause_nxt = r_pause_cnt + 8'd1;
                    end
                end
            end
            S_SERVE: begin
                if (w_serve_ev) begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_OVER: begin
                if (w_serve_ev) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and outputs; outputs are decoded from the next state so they change with it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pause_cnt   <= 8'd0;
            score_bcd     <= 8'h00;
            lives_left    <= c_LIVES;
            ball_run      <= 1'b0;
            ball_recenter <= 1'b1;
            game_over     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pause_cnt   <= w_pause_nxt;
            score_bcd     <= w_score_nxt;
            lives_left    <= w_lives_nxt;
            ball_run      <= (w_state_nxt == S_PLAY);
            ball_recenter <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_PAUSE) ||
                             (w_state_nxt == S_SERVE);
            game_over     <= (w_state_nxt == S_OVER);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_game_ctrl
// Description : Self-checking bench for pong_game_ctrl using an expectation
//               queue popped one clock after each stimulus step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_PLAY  = 3'd1;
    localparam logic [2:0] c_PAUSE = 3'd2;
    localparam logic [2:0] c_SERVE = 3'd3;
    localparam logic [2:0] c_OVER  = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       serve_btn = 1'b0;
    logic       paddle_hit = 1'b0;
    logic [8:0] ball_y = 9'd100;
    logic       ball_run;
    logic       ball_recenter;
    logic [7:0] score_bcd;
    logic [2:0] lives_left;
    logic       game_over;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [7:0] score;
        int         lives;   // negative: not checked
    } exp_t;

    exp_t sb_q[$];

    pong_game_ctrl #(
        .LIVES        (3),
        .MISS_Y       (470),
        .PAUSE_FRAMES (60)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .serve_btn     (serve_btn),
        .paddle_hit    (paddle_hit),
        .ball_y        (ball_y),
        .ball_run      (ball_run),
        .ball_recenter (ball_recenter),
        .score_bcd     (score_bcd),
        .lives_left    (lives_left),
        .game_over     (game_over),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        int v;
        v = (n > 99) ? 99 : n;
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic push_exp(input string tag, input logic [2:0] st, input logic [7:0] sc, input int lv);
        exp_t e;
        e.tag   = tag;
        e.st    = st;
        e.score = sc;
        e.lives = lv;
        sb_q.push_back(e);
    endtask

    // One clock; pending expectation is compared 1 ns after the edge
    task automatic cyc();
        exp_t e;
        logic exp_run, exp_rec, exp_go;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e       = sb_q.pop_front();
            exp_run = (e.st == c_PLAY);
            exp_rec = (e.st == c_IDLE) || (e.st == c_PAUSE) || (e.st == c_SERVE);
            exp_go  = (e.st == c_OVER);
            check_val({e.tag, ".state"},    32'(state_o),       32'(e.st));
            check_val({e.tag, ".run"},      32'(ball_run),      32'(exp_run));
            check_val({e.tag, ".recenter"}, 32'(ball_recenter), 32'(exp_rec));
            check_val({e.tag, ".game_over"},32'(game_over),     32'(exp_go));
            check_val({e.tag, ".score"},    32'(score_bcd),     32'(e.score));
            if (e.lives >= 0) begin
                check_val({e.tag, ".lives"}, 32'(lives_left), 32'(e.lives));
            end
        end
    endtask

    // Press and release the button; the third sampling edge is where the FSM reacts
    task automatic serve_press(input string tag, input logic [2:0] st, input logic [7:0] sc, input int lv);
        serve_btn = 1'b1;
        cyc();
        cyc();
        push_exp(tag, st, sc, lv);
        cyc();
        serve_btn = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic miss(input string tag, input logic [2:0] st, input logic [7:0] sc, input int lv);
        ball_y     = 9'd470;
        frame_tick = 1'b1;
        push_exp(tag, st, sc, lv);
        cyc();
        frame_tick = 1'b0;
        ball_y     = 9'd100;
    endtask

    task automatic hit(input string tag, input logic [2:0] st, input logic [7:0] sc, input int lv);
        paddle_hit = 1'b1;
        push_exp(tag, st, sc, lv);
        cyc();
        paddle_hit = 1'b0;
    endtask

    // Full pause: SERVE must appear on exactly the 60th frame tick
    task automatic pause_run(input logic [7:0] sc, input int lv);
        for (int k = 1; k <= 60; k++) begin
            push_exp($sformatf("pause_f%0d", k), (k == 60) ? c_SERVE : c_PAUSE, sc, lv);
            frame();
        end
    endtask

    initial begin
        // 1. reset and first serve
        rst = 1'b1;
        push_exp("reset", c_IDLE, 8'h00, 3);
        cyc();
        rst = 1'b0;
        serve_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            push_exp($sformatf("serve_hold%0d", i), (i >= 3) ? c_PLAY : c_IDLE, 8'h00, 3);
            cyc();
        end
        serve_btn = 1'b0;
        cyc();
        cyc();
        cyc();

        // ball just above the miss line does not count
        ball_y     = 9'd469;
        frame_tick = 1'b1;
        push_exp("no_miss_469", c_PLAY, 8'h00, 3);
        cyc();
        frame_tick = 1'b0;
        ball_y     = 9'd100;

        // 2. scoring up to saturation
        for (int n = 1; n <= 100; n++) begin
            hit($sformatf("hit%0d", n), c_PLAY, to_bcd(n), 3);
        end

        // 3. miss, pause behaviour, serve back into play
        miss("miss1", c_PAUSE, 8'h99, 2);
        serve_press("serve_in_pause", c_PAUSE, 8'h99, 2);
        hit("hit_in_pause", c_PAUSE, 8'h99, 2);
        pause_run(8'h99, 2);
        serve_press("serve_after_pause", c_PLAY, 8'h99, 2);

        // 4. run out of lives, then back through IDLE
        miss("miss2", c_PAUSE, 8'h99, 1);
        pause_run(8'h99, 1);
        serve_press("serve2", c_PLAY, 8'h99, 1);
        miss("miss3", c_OVER, 8'h99, 0);
        hit("hit_in_over", c_OVER, 8'h99, 0);
        serve_press("serve_over", c_IDLE, 8'h99, -1);
        serve_press("serve_new_game", c_PLAY, 8'h00, 3);

        // 5. hit and miss in the same cycle
        for (int n = 1; n <= 5; n++) begin
            hit($sformatf("g2_hit%0d", n), c_PLAY, to_bcd(n), 3);
        end
        miss("g2_miss1", c_PAUSE, 8'h05, 2);
        pause_run(8'h05, 2);
        serve_press("g2_serve", c_PLAY, 8'h05, 2);
        paddle_hit = 1'b1;
        ball_y     = 9'd470;
        frame_tick = 1'b1;
        push_exp("hit_and_miss", c_PAUSE, 8'h06, 1);
        cyc();
        paddle_hit = 1'b0;
        frame_tick = 1'b0;
        ball_y     = 9'd100;

        // 6. reset in the middle of a pause, then the pause counter must start from zero
        for (int k = 1; k <= 30; k++) begin
            push_exp($sformatf("pre_rst_f%0d", k), c_PAUSE, 8'h06, 1);
            frame();
        end
        rst = 1'b1;
        push_exp("mid_pause_reset", c_IDLE, 8'h00, 3);
        cyc();
        rst = 1'b0;
        push_exp("post_reset_idle", c_IDLE, 8'h00, 3);
        cyc();
        serve_press("g3_serve", c_PLAY, 8'h00, 3);
        miss("g3_miss1", c_PAUSE, 8'h00, 2);
        pause_run(8'h00, 2);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
